// File: rtl/man_encoder.sv
// rtl/man_encoder.sv - Manchester line encoder: parallel word in, MSB-first Manchester line out
module man_encoder #(
  parameter int HALF_BIT = 4,
  parameter int WIDTH    = 8,
  parameter int GAP_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int GAP_CYC = GAP_BITS * 2 * HALF_BIT;
  localparam int HW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(HALF_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic             phase_q, phase_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             out_q, out_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      hcnt_q  <= '0;
      phase_q <= 1'b0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      hcnt_q  <= hcnt_d;
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    hcnt_d  = hcnt_q;
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    out_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_SEND;
          sr_d    = din;
          hcnt_d  = '0;
          phase_d = 1'b0;
          bcnt_d  = '0;
        end
      end
      S_SEND: begin
        if (hcnt_q == H_LAST) begin
          hcnt_d  = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bcnt_q == B_LAST) begin
              state_d = S_GAP;
              gcnt_d  = '0;
            end else begin
              sr_d   = {sr_q[WIDTH-2:0], 1'b0};
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt_q == G_LAST) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Line level is computed from next state so the flop presents it in the same cycle.
    if (state_d == S_SEND) begin
      out_d = sr_d[WIDTH-1] ^ ~phase_d;
    end
  end

  assign out   = out_q;
  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_SEND) || (state_q == S_GAP);
  assign done  = (state_q == S_GAP) && (gcnt_q == '0);

endmodule

// File: tb/tb_man_encoder.sv
// tb/tb_man_encoder.sv - self-checking bench for man_encoder against a frame-offset model
module tb_man_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din0, din1;
  logic [1:0] din2;
  logic       ld0, ld1, ld2;
  logic       r0, o0, b0, d0;
  logic       r1, o1, b1, d1;
  logic       r2, o2, b2, d2;

  man_encoder #(.HALF_BIT(4), .WIDTH(8), .GAP_BITS(2)) u_def (
    .clk(clk), .rst(rst), .din(din0), .load(ld0),
    .ready(r0), .out(o0), .busy(b0), .done(d0));
  man_encoder #(.HALF_BIT(2), .WIDTH(8), .GAP_BITS(2)) u_hb2 (
    .clk(clk), .rst(rst), .din(din1), .load(ld1),
    .ready(r1), .out(o1), .busy(b1), .done(d1));
  man_encoder #(.HALF_BIT(1), .WIDTH(2), .GAP_BITS(1)) u_edge (
    .clk(clk), .rst(rst), .din(din2), .load(ld2),
    .ready(r2), .out(o2), .busy(b2), .done(d2));

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model state: offset of the current cycle within an accepted frame, -1 when idle.
  int p0 = -1, p1 = -1, p2 = -1;
  int w0 = 0, w1 = 0, w2 = 0;

  task automatic step(input int hb, input int w, input int g, input logic ld,
                      input int dn, inout int p, inout int wd);
    if (p < 0) begin
      if (ld) begin
        p  = 0;
        wd = dn;
      end
    end else begin
      p++;
      if (p >= (w + g) * 2 * hb) p = -1;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0 = -1;
      p1 = -1;
      p2 = -1;
    end else begin
      step(4, 8, 2, ld0, int'(din0), p0, w0);
      step(2, 8, 2, ld1, int'(din1), p1, w1);
      step(1, 2, 1, ld2, int'(din2), p2, w2);
    end
  end

  task automatic cmp(input string tag, input int hb, input int w, input int p, input int wd,
                     input logic o, input logic b, input logic d, input logic r);
    logic eo, eb, ed, er;
    int   bit_v;
    eo = 1'b0; eb = 1'b0; ed = 1'b0; er = 1'b1;
    if (p >= 0) begin
      eb = 1'b1;
      er = 1'b0;
      if (p < w * 2 * hb) begin
        bit_v = (wd >> (w - 1 - p / (2 * hb))) & 1;
        eo = ((p % (2 * hb)) >= hb) ? bit_v[0] : ~bit_v[0];
      end else begin
        ed = (p == w * 2 * hb);
      end
    end
    check({tag, "_out"}, 32'(o), 32'(eo));
    check({tag, "_busy"}, 32'(b), 32'(eb));
    check({tag, "_done"}, 32'(d), 32'(ed));
    check({tag, "_ready"}, 32'(r), 32'(er));
  endtask

  always @(negedge clk) begin
    cmp("def", 4, 8, p0, w0, o0, b0, d0, r0);
    cmp("hb2", 2, 8, p1, w1, o1, b1, d1, r1);
    cmp("edge", 1, 2, p2, w2, o2, b2, d2, r2);
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic pulse0(input logic [7:0] v);
    @(posedge clk); #2 ld0 = 1'b1; din0 = v;
    @(posedge clk); #2 ld0 = 1'b0;
  endtask

  logic [31:0] cap;
  logic [7:0]  f1, f2;
  int          cnt_a, cnt_b, cnt_c, cnt_d, dn1, dn2;
  logic        prev;

  initial begin
    rst = 1'b0;
    ld0 = 1'b0; ld1 = 1'b0; ld2 = 1'b0;
    din0 = '0; din1 = '0; din2 = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(r0), 32'd1);
    check("reset_out", 32'(o0), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic encode, HALF_BIT=2, A5
    #2 ld1 = 1'b1; din1 = 8'hA5;
    @(posedge clk); #2 ld1 = 1'b0;
    cap = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); cap = {cap[30:0], o1};
    end
    check("basic_out", cap, 32'h3C3CC3C3);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) check("basic_done_first", 32'(d1), 32'd1);
      cnt_a += int'(d1);
      cnt_b += int'(o1);
    end
    check("basic_done_count", cnt_a, 1);
    check("basic_gap_out", cnt_b, 0);
    @(negedge clk); check("basic_ready_back", 32'(r1), 32'd1);

    // Timing counts, defaults, FF
    pulse0(8'hFF);
    prev = 1'b0; cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (o0 && !prev) begin
        cnt_a++;
        if (i % 8 != 4) cnt_b++;
      end
      prev = o0;
      if (!r0) cnt_c++;
      if (b0 !== !r0) cnt_d++;
    end
    check("timing_rises", cnt_a, 8);
    check("timing_rise_offset", cnt_b, 0);
    check("timing_ready_low", cnt_c, 80);
    check("timing_busy_compl", cnt_d, 0);
    @(negedge clk); check("timing_ready_back", 32'(r0), 32'd1);

    // Load while busy
    pulse0(8'h3C);
    f1 = '0; cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i < 64 && i % 8 == 4) f1 = {f1[6:0], o0};
      cnt_a += int'(d0);
      cnt_b += int'(b0);
      #1;
      if (i == 20) begin ld0 = 1'b1; din0 = 8'h00; end
      if (i == 21) ld0 = 1'b0;
    end
    check("busy_load_data", 32'(f1), 32'h3C);
    check("busy_load_done", cnt_a, 1);
    check("busy_load_busy_cycles", cnt_b, 80);

    // Back-to-back with load held high
    @(posedge clk); #2 ld0 = 1'b1; din0 = 8'h81;
    @(posedge clk); #2 din0 = 8'h7E;
    f1 = '0; f2 = '0; dn1 = -1; dn2 = -1;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (i < 64 && i % 8 == 4) f1 = {f1[6:0], o0};
      if (i >= 81 && i < 145 && (i - 81) % 8 == 4) f2 = {f2[6:0], o0};
      if (d0) begin
        if (dn1 < 0) dn1 = i;
        else if (dn2 < 0) dn2 = i;
      end
      #1;
      if (i == 100) ld0 = 1'b0;
    end
    check("b2b_frame1", 32'(f1), 32'h81);
    check("b2b_frame2", 32'(f2), 32'h7E);
    check("b2b_done1", dn1, 64);
    check("b2b_period", dn2 - dn1, 81);

    // Reset mid-frame during bit 3 of C3
    pulse0(8'hC3);
    for (int i = 0; i < 28; i++) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_out", 32'(o0), 32'd0);
    check("rst_ready", 32'(r0), 32'd1);
    check("rst_busy", 32'(b0), 32'd0);
    check("rst_done", 32'(d0), 32'd0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk); cnt_a += int'(d0);
    end
    check("rst_no_done", cnt_a, 0);
    pulse0(8'h5A);
    f1 = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 0) check("rst_fresh_first", 32'(o0), 32'd1);
      if (i % 8 == 4) f1 = {f1[6:0], o0};
    end
    check("rst_fresh_data", 32'(f1), 32'h5A);
    repeat (20) @(negedge clk);

    // Edge parameters
    @(posedge clk); #2 ld2 = 1'b1; din2 = 2'b10;
    @(posedge clk); #2 ld2 = 1'b0;
    cap = '0; cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cap = {cap[30:0], o2};
      if (!r2) cnt_a++;
    end
    check("edge_out", cap, 32'b011000);
    check("edge_ready_low", cnt_a, 6);
    @(negedge clk); check("edge_ready_back", 32'(r2), 32'd1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
